// File: rtl/dmem_lat.sv
// -----------------------------------------------------------------------------
// dmem_lat : single-transaction data memory with a req/ready handshake and
// separate, fixed read and write latencies.
//
// A request is accepted while idle. Its address, direction, byte enables, write
// data and error status are captured at that edge. After RD_DELAY (read) or
// WR_DELAY (write) further edges, the access is performed. The response is then
// presented for exactly one cycle, and the block is ready again in that cycle.
//
// Parameters
//   DW        data width in bits (multiple of 8), BW = DW/8 byte lanes
//   AW        byte-address width
//   DEPTH     number of DW-bit words
//   RD_DELAY  read latency in cycles (>= 1)
//   WR_DELAY  write latency in cycles (>= 1)
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-high reset (memory contents are kept)
//   i_req    request valid
//   o_ready  request can be accepted this cycle
//   i_we     1 = write, 0 = read
//   i_be     byte-lane write enables (writes only)
//   i_addr   byte address
//   i_wdata  write data
//   o_rvd    read response valid (1-cycle pulse)
//   o_rdata  read data, zero unless o_rvd
//   o_wack   write acknowledge (1-cycle pulse)
//   o_err    misaligned / out-of-range flag, only with o_rvd or o_wack
// -----------------------------------------------------------------------------
module dmem_lat #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int DEPTH    = 8192,
  parameter int RD_DELAY = 5,
  parameter int WR_DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  output logic            o_ready,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic            o_rvd,
  output logic [DW-1:0]   o_rdata,
  output logic            o_wack,
  output logic            o_err
);

  localparam int BW   = DW / 8;
  localparam int BSH  = (BW > 1) ? $clog2(BW) : 0;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXD = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int CW   = $clog2(MAXD + 1);

  // Low address bits that must be zero for a lane-aligned access.
  localparam logic [AW-1:0] ALIGN_MASK = AW'(BW - 1);
  localparam logic [AW-1:0] DEPTH_A    = AW'(DEPTH);
  localparam logic [CW-1:0] RD_N       = CW'(RD_DELAY);
  localparam logic [CW-1:0] WR_N       = CW'(WR_DELAY);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Merge new write data into an existing word, lane by lane.
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [BW-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_w[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_w[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Backing storage; deliberately not reset.
  logic [DW-1:0] mem_q [DEPTH];

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] n_q;
  logic          we_q;
  logic [BW-1:0] be_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;

  logic          o_ready_q;
  logic          o_rvd_q;
  logic          o_wack_q;
  logic          o_err_q;
  logic [DW-1:0] o_rdata_q;

  logic [AW-1:0] word_idx_s;
  logic          mis_s;
  logic          oor_s;
  logic          done_s;
  logic          wr_en_s;
  logic [DW-1:0] rd_word_s;
  logic [DW-1:0] mem_wdata_d;

  // Request classification, evaluated on the live inputs at accept time.
  assign word_idx_s = i_addr >> BSH;
  assign mis_s      = |(i_addr & ALIGN_MASK);
  assign oor_s      = (word_idx_s >= DEPTH_A);

  // The access happens on the edge where the wait counter reaches N.
  assign done_s      = (state_q == ST_WAIT) && (cnt_q == n_q);
  // Erroneous writes never touch storage; reset also blocks the write.
  assign wr_en_s     = done_s && we_q && !err_q && !rst;
  assign rd_word_s   = mem_q[idx_q];
  assign mem_wdata_d = merge_lanes(rd_word_s, wdata_q, be_q);

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_q] <= mem_wdata_d;
    end
  end

  // Handshake FSM: capture, latency count and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      n_q       <= CNT_ZERO;
      we_q      <= 1'b0;
      be_q      <= {BW{1'b0}};
      idx_q     <= {IW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      err_q     <= 1'b0;
      o_ready_q <= 1'b1;
      o_rvd_q   <= 1'b0;
      o_wack_q  <= 1'b0;
      o_err_q   <= 1'b0;
      o_rdata_q <= {DW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Any response pulse from the previous transaction ends here.
          o_rvd_q   <= 1'b0;
          o_wack_q  <= 1'b0;
          o_err_q   <= 1'b0;
          o_rdata_q <= {DW{1'b0}};
          if (i_req) begin
            we_q      <= i_we;
            be_q      <= i_be;
            idx_q     <= word_idx_s[IW-1:0];
            wdata_q   <= i_wdata;
            err_q     <= mis_s | oor_s;
            n_q       <= i_we ? WR_N : RD_N;
            cnt_q     <= CNT_ONE;
            state_q   <= ST_WAIT;
            o_ready_q <= 1'b0;
          end else begin
            o_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == n_q) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            o_ready_q <= 1'b1;
            o_rvd_q   <= !we_q;
            o_wack_q  <= we_q;
            o_err_q   <= err_q;
            // Write responses and failed reads carry no data.
            o_rdata_q <= (!we_q && !err_q) ? rd_word_s : {DW{1'b0}};
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= CNT_ZERO;
          o_ready_q <= 1'b1;
          o_rvd_q   <= 1'b0;
          o_wack_q  <= 1'b0;
          o_err_q   <= 1'b0;
          o_rdata_q <= {DW{1'b0}};
        end
      endcase
    end
  end

  assign o_ready = o_ready_q;
  assign o_rvd   = o_rvd_q;
  assign o_wack  = o_wack_q;
  assign o_err   = o_err_q;
  assign o_rdata = o_rdata_q;

endmodule
